// File: rtl/regfile_sb.sv
// Parametrised register file with combinational read ports, optional write-to-read
// bypass and a per-register busy scoreboard whose population count is registered.
module regfile_sb #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NRD*AW-1:0]   i_rd_addr,
  output logic [NRD*XLEN-1:0] o_rd_data,
  output logic [NRD-1:0]      o_rd_busy,
  input  logic                i_wr_en,
  input  logic [AW-1:0]       i_wr_addr,
  input  logic [XLEN-1:0]     i_wr_data,
  input  logic                i_iss_en,
  input  logic [AW-1:0]       i_iss_addr,
  output logic [AW:0]         o_busy_cnt,
  output logic                o_idle
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [AW:0]      r_busy_cnt;
  logic             r_idle;

  logic [NREGS-1:0] w_busy_nxt;
  logic [AW:0]      w_busy_cnt_nxt;
  logic             w_wr_ok;
  logic             w_iss_ok;

  assign w_wr_ok  = i_wr_en && (i_wr_addr != '0);
  assign w_iss_ok = i_iss_en && (i_iss_addr != '0);

  // Issue is applied after writeback so a same-address pair leaves the register busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok)  w_busy_nxt[i_wr_addr]  = 1'b0;
    if (w_iss_ok) w_busy_nxt[i_iss_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
    w_busy_cnt_nxt = '0;
    for (int k = 0; k < NREGS; k++) begin
      w_busy_cnt_nxt = w_busy_cnt_nxt + (AW+1)'(w_busy_nxt[k]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
      r_idle     <= 1'b1;
      for (int k = 0; k < NREGS; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
      r_idle     <= (w_busy_cnt_nxt == '0);
      if (w_wr_ok) r_regs[i_wr_addr] <= i_wr_data;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] w_ra;
    logic          w_hit;

    assign w_ra  = i_rd_addr[g*AW +: AW];
    assign w_hit = (BYPASS != 0) && w_wr_ok && (i_wr_addr == w_ra);

    assign o_rd_data[g*XLEN +: XLEN] = (w_ra == '0) ? '0 :
                                       w_hit        ? i_wr_data : r_regs[w_ra];
    // A forwarded write clears busy unless the same register is re-issued this cycle.
    assign o_rd_busy[g] = w_hit ? (i_iss_en && (i_iss_addr == i_wr_addr)) : r_busy[w_ra];
  end

  assign o_busy_cnt = r_busy_cnt;
  assign o_idle     = r_idle;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised integer register file for the pipelined core. Adds configurable width, depth and read-port count to the register file. Adds synchronous clear, optional write-to-read bypass, and a per-register busy scoreboard for hazard detection between issue and writeback. Sits between decode (read and issue ports) and writeback (write port).

Parameters:
XLEN, 32, data width in bits.
NREGS, 32, number of architectural registers; power of two, minimum 2.
NRD, 2, number of combinational read ports, 1 to 4.
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = no forwarding.
AW, $clog2(NREGS), address width; derived, not overridden.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst_n  in  1  synchronous active-low reset.
rd_addr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
rd_data  out  NRD*XLEN  read data per port.
rd_busy  out  NRD  per-port busy flag of the addressed register.
wr_en  in  1  writeback enable.
wr_addr  in  AW  writeback destination.
wr_data  in  XLEN  writeback data.
iss_en  in  1  issue: mark destination as pending.
iss_addr  in  AW  issued destination.
busy_cnt  out  AW+1  number of registers currently busy (registered).
idle  out  1  1 when busy_cnt == 0.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at posedge): every register cleared to 0, every busy bit cleared, busy_cnt=0, idle=1. Reset overrides wr_en and iss_en in the same cycle. Reset mid-operation discards all pending busy state.
- Register 0: always reads 0 and is never busy. Writes and issues to address 0 are ignored, with no state change.
- Read path is combinational (0-cycle latency):
  - rd_data[i] = regs[rd_addr[i]].
  - rd_busy[i] = busy[rd_addr[i]].
- Bypass (BYPASS=1): if wr_en && wr_addr==rd_addr[i] && wr_addr!=0, then rd_data[i]=wr_data and rd_busy[i]=0, unless iss_en && iss_addr==wr_addr in the same cycle, in which case rd_busy[i]=1.
- BYPASS=0: reads return the pre-edge register contents and busy bit, with no forwarding.
- Write (wr_en, wr_addr!=0): regs[wr_addr] <= wr_data at posedge and busy[wr_addr] <= 0.
  - A write to a non-busy register is legal; it updates data and busy stays 0.
- Issue (iss_en, iss_addr!=0): busy[iss_addr] <= 1 at posedge. Re-issuing an already-busy register is legal and leaves busy at 1.
- Simultaneous write and issue:
  - Same address: data is written and busy ends at 1 (issue wins).
  - Different addresses: both take effect.
- busy_cnt: registered population count of busy[]. It is updated every cycle from next-state busy, so it reflects the state after the edge. Range 0 to NREGS-1. Increments/decrements by at most 1 per cycle, except same-address write+issue (net 0 if already busy, +1 if not).
- idle = (busy_cnt==0), registered alongside busy_cnt.
- No internal FSM beyond the busy bit array and counter. All outputs are defined at every cycle after the first reset.

Test Plan:
- Reset clear: write 0xDEADBEEF to x5, issue x7, assert rst_n=0 for 1 cycle. Then read x5 gives 0, rd_busy(x7)=0, busy_cnt=0, idle=1.
- x0 immunity: wr_en with wr_addr=0, wr_data=0xFFFFFFFF, plus iss_en with iss_addr=0. Then rd_data(x0)=0, rd_busy=0, busy_cnt unchanged.
- Scoreboard: issue x3 at cycle 1; at cycle 2 rd_busy(x3)=1 and busy_cnt=1. Write x3=0x12345678 at cycle 4. At cycle 5 rd_busy=0, rd_data=0x12345678, busy_cnt=0, idle=1.
- Bypass: with BYPASS=1, x9 busy, drive wr_en x9=0xCAFEF00D and rd_addr port1=9 in the same cycle. The same cycle shows rd_data[1]=0xCAFEF00D and rd_busy[1]=0. With BYPASS=0, the same stimulus returns the old value and rd_busy=1.
- Same-address write+issue: x4 busy with old value 0x1. Write x4=0x55 and issue x4 in the same cycle. Next cycle rd_data=0x55, rd_busy=1, busy_cnt unchanged.
- Parameter sweep: XLEN=64, NREGS=16, NRD=3. Fill all 15 registers, issue all 15 (busy_cnt=15), then write all back in reverse order. busy_cnt decrements to 0 one per cycle, and all three ports read correct 64-bit values concurrently.
